// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

  // Direction and boundary-mode encodings as seen on the dir/sat inputs.
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Limit a load value to the counter range 0..modulo-1. 32-bit operands keep
  // the comparison free of truncation for any WIDTH up to 16.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] modulo);
    return (val >= modulo) ? (modulo - 32'd1) : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-strobe generator: emits tick on every PRESCALE-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Next prescaler value and the combinational step strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down modulo counter with wrap/saturate modes, prescaler, load/clear,
// compare match, terminal-count pulse and sticky overflow flag.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] count_inc, count_dec;

  // Clear and load both restart the prescaler so the next step is a full
  // period away.
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (clear | load),
    .tick    (tick)
  );

  assign count_inc = count_q + 1'b1;
  assign count_dec = count_q - 1'b1;

  // Next count, terminal-count pulse, overflow and registered compare.
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    boundary = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = WIDTH'(clamp_load(32'(load_val), 32'(MODULO)));
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (count_q == MAX) begin
          boundary = 1'b1;
          if (sat == MODE_WRAP) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_inc;
          // In saturate mode the pulse marks arrival at the limit.
          tc_d    = (sat == MODE_SAT) && (count_inc == MAX);
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          if (sat == MODE_WRAP) begin
            count_d = MAX;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_dec;
          tc_d    = (sat == MODE_SAT) && (count_dec == '0);
        end
      end
    end
    // A boundary event outranks a same-edge clr_ovf.
    if (boundary)     ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
    // count_d never exceeds MODULO-1, so an out-of-range cmp_val never matches.
    match_d = (count_d == cmp_val);
  end

  // Output registers; reset forces the count to zero and compares against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      match_q <= (cmp_val == '0);
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign match = match_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: instance A (MODULO=10, PRESCALE=1)
// and instance B (MODULO=10, PRESCALE=4) share the stimulus inputs.
module tb_param_updown_counter;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       ovf;
    logic       match;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       dir;
    logic       sat;
    logic       load;
    logic [7:0] load_val;
    logic       clear;
    logic       clr_ovf;
    exp_t       exp;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst, en, dir, sat, load, clear, clr_ovf;
  logic [7:0] load_val, cmp_val;
  logic [7:0] a_count, b_count;
  logic       a_tc, a_match, a_ovf;
  logic       b_tc, b_match, b_ovf;

  exp_t  sb_q[$];
  exp_t  e;
  stim_t s[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .clear(clear), .cmp_val(cmp_val), .clr_ovf(clr_ovf),
    .count(a_count), .tc(a_tc), .match(a_match), .ovf(a_ovf)
  );

  param_updown_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .clear(clear), .cmp_val(cmp_val), .clr_ovf(clr_ovf),
    .count(b_count), .tc(b_tc), .match(b_match), .ovf(b_ovf)
  );

  function automatic stim_t mk(input logic r, input logic en_i, input logic dir_i,
                               input logic sat_i, input logic ld, input logic [7:0] lv,
                               input logic clr, input logic co, input logic [7:0] c,
                               input logic t, input logic o, input logic m);
    stim_t x;
    x.rst = r; x.en = en_i; x.dir = dir_i; x.sat = sat_i; x.load = ld;
    x.load_val = lv; x.clear = clr; x.clr_ovf = co;
    x.exp = '{count: c, tc: t, ovf: o, match: m};
    return x;
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b0; dir = 1'b1; sat = 1'b0; load = 1'b0;
    clear = 1'b0; clr_ovf = 1'b0; load_val = 8'd0; cmp_val = 8'hFF;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the outcome expected after the edge.
  task automatic apply(input stim_t x);
    rst = x.rst; en = x.en; dir = x.dir; sat = x.sat; load = x.load;
    load_val = x.load_val; clear = x.clear; clr_ovf = x.clr_ovf;
    sb_q.push_back(x.exp);
  endtask

  task automatic test_reset();
    idle_inputs();
    en = 1'b1;
    cmp_val = 8'd0;
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      sb_q.push_back('{count: 8'd0, tc: 1'b0, ovf: 1'b0, match: (i == 0)});
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({a_count, a_tc, a_ovf, a_match} !== e) begin
        errors++;
        $display("FAIL reset_a %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, a_count, a_tc, a_ovf, a_match, e.count, e.tc, e.ovf, e.match);
      end
      checks++;
      if ({b_count, b_tc, b_ovf, b_match} !== e) begin
        errors++;
        $display("FAIL reset_b %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, b_count, b_tc, b_ovf, b_match, e.count, e.tc, e.ovf, e.match);
      end
      cmp_val = 8'd7;
    end
    idle_inputs();
  endtask

  task automatic test_wrap_up();
    idle_inputs();
    apply_reset();
    s.delete();
    for (int k = 1; k <= 12; k++)
      s.push_back(mk(0, 1, 1, 0, 0, 8'd0, 0, 0, 8'(k % 10), k == 10, k >= 10, 0));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({a_count, a_tc, a_ovf, a_match} !== e) begin
        errors++;
        $display("FAIL wrap_up %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, a_count, a_tc, a_ovf, a_match, e.count, e.tc, e.ovf, e.match);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    idle_inputs();
    apply_reset();
    s.delete();
    s.push_back(mk(0, 0, 0, 1, 1, 8'd2, 0, 0, 8'd2, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      s.push_back(mk(0, 1, 0, 1, 0, 8'd0, 0, 0, (k < 2) ? 8'd1 : 8'd0, k == 2, k >= 3, 0));
    // Load with clr_ovf drops the flag; then saturate going up.
    s.push_back(mk(0, 0, 1, 1, 1, 8'd8, 0, 1, 8'd8, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      s.push_back(mk(0, 1, 1, 1, 0, 8'd0, 0, 0, 8'd9, k == 1, k >= 2, 0));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({a_count, a_tc, a_ovf, a_match} !== e) begin
        errors++;
        $display("FAIL saturate %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, a_count, a_tc, a_ovf, a_match, e.count, e.tc, e.ovf, e.match);
      end
    end
    idle_inputs();
  endtask

  task automatic test_prescale();
    idle_inputs();
    apply_reset();
    s.delete();
    for (int k = 1; k <= 12; k++)
      s.push_back(mk(0, 1, 1, 0, 0, 8'd0, 0, 0, 8'(k / 4), 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      s.push_back(mk(0, 0, 1, 0, 0, 8'd0, 0, 0, 8'd3, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({b_count, b_tc, b_ovf, b_match} !== e) begin
        errors++;
        $display("FAIL prescale %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, b_count, b_tc, b_ovf, b_match, e.count, e.tc, e.ovf, e.match);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_clear();
    idle_inputs();
    apply_reset();
    s.delete();
    s.push_back(mk(0, 0, 1, 0, 1, 8'd3,   0, 0, 8'd3, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 8'd5,   1, 0, 8'd0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 8'd200, 0, 0, 8'd9, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 8'd9,   0, 0, 8'd9, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 8'd10,  0, 0, 8'd9, 0, 0, 0));
    s.push_back(mk(0, 1, 1, 0, 1, 8'd4,   0, 0, 8'd4, 0, 0, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 8'd0,   1, 0, 8'd0, 0, 0, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 8'd0,   0, 0, 8'd1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({a_count, a_tc, a_ovf, a_match} !== e) begin
        errors++;
        $display("FAIL load_clear %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, a_count, a_tc, a_ovf, a_match, e.count, e.tc, e.ovf, e.match);
      end
    end
    idle_inputs();
  endtask

  task automatic test_match_ovf();
    idle_inputs();
    cmp_val = 8'd7;
    apply_reset();
    s.delete();
    for (int k = 1; k <= 20; k++)
      s.push_back(mk(0, 1, 1, 0, 0, 8'd0, 0, (k == 11) || (k == 20),
                     8'(k % 10), (k % 10) == 0, (k == 10) || (k == 20), (k % 10) == 7));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({a_count, a_tc, a_ovf, a_match} !== e) begin
        errors++;
        $display("FAIL match_ovf %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, a_count, a_tc, a_ovf, a_match, e.count, e.tc, e.ovf, e.match);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    apply_reset();
    s.delete();
    s.push_back(mk(0, 0, 1, 0, 1, 8'd8, 0, 0, 8'd8, 0, 0, 0));
    for (int k = 1; k <= 34; k++)
      s.push_back(mk(0, 1, 1, 0, 0, 8'd0, 0, 0, 8'((8 + k / 4) % 10), k == 8, k >= 8, 0));
    s.push_back(mk(1, 1, 1, 0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      s.push_back(mk(0, 1, 1, 0, 0, 8'd0, 0, 0, 8'(k / 4), 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({b_count, b_tc, b_ovf, b_match} !== e) begin
        errors++;
        $display("FAIL mid_reset %0d: got count=%0d tc=%b ovf=%b match=%b, expected count=%0d tc=%b ovf=%b match=%b",
                 i, b_count, b_tc, b_ovf, b_match, e.count, e.tc, e.ovf, e.match);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wrap_up();
    test_saturate();
    test_prescale();
    test_load_clear();
    test_match_ovf();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's single-width free-running counter. It provides:
- up/down counting with a programmable modulo;
- wrap or saturate mode;
- a clock prescaler, synchronous load/clear, compare match, terminal-count pulse and a sticky overflow flag.

It sits behind the tt_um top-level pin mapping, so ui_in/uio_in drive the controls and uo_out carries the count.

Parameters:
WIDTH, 8, count register width in bits (2..16)
MODULO, 256, count range 0..MODULO-1; must satisfy 2 <= MODULO <= 2**WIDTH
PRESCALE, 1, enabled cycles per count step (1 = every cycle); prescaler width is $clog2(PRESCALE)+1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  count enable; gates the prescaler
dir  in  1  1 = count up, 0 = count down
sat  in  1  1 = saturate at the range limit, 0 = wrap modulo MODULO
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
clear  in  1  synchronous clear of count to 0
cmp_val  in  WIDTH  compare value
clr_ovf  in  1  clears the sticky ovf flag
count  out  WIDTH  current count, registered
tc  out  1  one-cycle terminal-count pulse, registered
match  out  1  count == cmp_val, registered (updates with count)
ovf  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst=1 at a clk edge) sets count=0, tc=0, match=(cmp_val==0) on the next cycle, ovf=0, prescaler=0. Reset has top priority and may be asserted mid-count.
- Priority per edge: rst > clear > load > step.
  - clear: count<=0, prescaler<=0, tc<=0.
  - load: count<=min(load_val, MODULO-1), prescaler<=0, tc<=0.
- Prescaler:
  - Increments only when en=1 and there is no clear/load.
  - When it reaches PRESCALE-1 while en=1, a step occurs on that edge and the prescaler returns to 0.
  - en=0 freezes both the prescaler and count.
  - With PRESCALE=1 a step occurs on every enabled edge.
- Step, up (dir=1):
  - count<MODULO-1: count+1.
  - count==MODULO-1 and sat=0: count<=0, tc<=1, ovf<=1.
  - count==MODULO-1 and sat=1: count holds, tc<=0, ovf<=1.
- Step, down (dir=0):
  - count>0: count-1.
  - count==0 and sat=0: count<=MODULO-1, tc<=1, ovf<=1.
  - count==0 and sat=1: count holds, ovf<=1, tc<=0.
- Saturate-mode tc: in sat mode, tc pulses on the step that arrives at the limit (MODULO-1 going up, 0 going down), never while holding at the limit.
- tc is 0 on every edge that is not one of the pulse events above, so it is always a single-cycle pulse.
- Latency: all outputs are registered. count, tc and match change on the same edge as the step, one cycle after the enabling input is sampled.
- match tracks the next count value (registered compare). A cmp_val >= MODULO never matches.
- ovf:
  - Set by any boundary step (wrap or saturation attempt).
  - Cleared by clr_ovf.
  - Set wins over clear on the same edge.
  - Cleared only by rst or clr_ovf; clear/load do not affect it.
- dir or sat changes take effect on the next step; there is no pipeline hazard.
- Arithmetic is WIDTH bits with no intermediate overflow; compare to MODULO-1 uses a WIDTH-bit constant.

Decomposition:
- counter_pkg: DIR_UP/DIR_DOWN and MODE_WRAP/MODE_SAT localparams, plus a function clamp_load(val, modulo).
- One sub-module, counter_prescaler (params PRESCALE; ports clk, rst, en, restart, tick), producing the step strobe.
- The top level holds the count register, boundary logic, tc, match and ovf.

Test Plan:
1. WIDTH=8, MODULO=10, PRESCALE=1, dir=1, sat=0, en=1 for 12 cycles after reset -> count 1..9,0,1,2; tc high exactly on the edge count goes 9->0; ovf=1 thereafter.
2. MODULO=10, dir=0, sat=1, load 2 then en=1 for 5 cycles -> count 1,0,0,0,0; tc pulses once at 1->0; ovf=1 from the first held cycle.
3. PRESCALE=4, dir=1, en=1 for 12 cycles, then en=0 for 3 cycles -> count steps every 4th enabled edge (1,2,3); frozen while en=0.
4. Simultaneous clear=1 and load=1 with load_val=5 -> count=0. Then load_val=200 with MODULO=10 -> count=9.
5. cmp_val=7, count up from 0 -> match high only while count==7. Then clr_ovf and a wrap on the same edge -> ovf stays 1.
6. rst asserted mid-count at count=6 with prescaler part-way -> next cycle count=0, tc=0, ovf=0; counting restarts a full PRESCALE period later.
